// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled serial receiver for 8N1-style frames.
// The raw line is synchronised first. A start bit is confirmed at its
// centre, each data bit is sampled at its centre (LSB first), and the stop
// bit is checked once. A completed frame is presented on data_out together
// with a one-clock rx_done pulse and a level framing_error flag.

module uart_receiver #(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx,
  input  logic             sample_tick,
  output logic [DBITS-1:0] data_out,
  output logic             rx_done,
  output logic             framing_error,
  output logic             rx_busy
);

  // Sample counter must reach both 15 (data bit length) and SB_TICK-1.
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  // Bit counter indexes the data bits; keep at least one bit for DBITS=1.
  localparam int NW = ($clog2(DBITS) > 1) ? $clog2(DBITS) : 1;

  localparam logic [SW-1:0] S_ZERO     = SW'(0);
  localparam logic [SW-1:0] S_ONE      = SW'(1);
  localparam logic [SW-1:0] S_MID      = SW'(7);
  localparam logic [SW-1:0] S_BIT_END  = SW'(15);
  localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_ZERO     = NW'(0);
  localparam logic [NW-1:0] N_ONE      = NW'(1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_r;
  logic [SW-1:0]    s_cnt_r;
  logic [NW-1:0]    n_cnt_r;
  logic [DBITS-1:0] shreg_r;
  logic             sync1_r;
  logic             rx_s;

  // Two-flop synchroniser for the asynchronous line; resets to the idle level.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= rx;
      rx_s    <= sync1_r;
    end
  end

  // Receive FSM with counters, shift register and registered outputs.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      s_cnt_r       <= S_ZERO;
      n_cnt_r       <= N_ZERO;
      shreg_r       <= {DBITS{1'b0}};
      data_out      <= {DBITS{1'b0}};
      rx_done       <= 1'b0;
      framing_error <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      // rx_done is a single-clock pulse unless the STOP branch raises it.
      rx_done <= 1'b0;
      case (state_r)
        IDLE: begin
          // A falling line starts a frame regardless of tick phase.
          if (!rx_s) begin
            state_r <= START;
            s_cnt_r <= S_ZERO;
            rx_busy <= 1'b1;
          end else begin
            rx_busy <= 1'b0;
          end
        end
        START: begin
          if (sample_tick) begin
            if (s_cnt_r == S_MID) begin
              if (!rx_s) begin
                // Start bit still low at its centre: real frame.
                state_r <= DATA;
                s_cnt_r <= S_ZERO;
                n_cnt_r <= N_ZERO;
              end else begin
                // Line recovered before the centre: glitch, drop it quietly.
                state_r <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              s_cnt_r <= s_cnt_r + S_ONE;
            end
          end
        end
        DATA: begin
          if (sample_tick) begin
            if (s_cnt_r == S_BIT_END) begin
              shreg_r <= {rx_s, shreg_r[DBITS-1:1]};
              s_cnt_r <= S_ZERO;
              if (n_cnt_r == N_LAST) begin
                state_r <= STOP;
              end else begin
                n_cnt_r <= n_cnt_r + N_ONE;
              end
            end else begin
              s_cnt_r <= s_cnt_r + S_ONE;
            end
          end
        end
        STOP: begin
          if (sample_tick) begin
            if (s_cnt_r == S_STOP_END) begin
              state_r       <= IDLE;
              data_out      <= shreg_r;
              framing_error <= ~rx_s;
              rx_done       <= 1'b1;
              rx_busy       <= 1'b0;
            end else begin
              s_cnt_r <= s_cnt_r + S_ONE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          s_cnt_r <= S_ZERO;
          n_cnt_r <= N_ZERO;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level scoreboard, a table of
// directed frames, hand-written corner sequences and randomized frames.

module tb_uart_receiver;

  logic       clk_100MHz;
  logic       reset;
  logic       rx;
  logic       sample_tick;
  logic [7:0] data_out;
  logic       rx_done;
  logic       framing_error;
  logic       rx_busy;

  uart_receiver #(.DBITS(8), .SB_TICK(16)) dut (
    .clk_100MHz   (clk_100MHz),
    .reset        (reset),
    .rx           (rx),
    .sample_tick  (sample_tick),
    .data_out     (data_out),
    .rx_done      (rx_done),
    .framing_error(framing_error),
    .rx_busy      (rx_busy)
  );

  localparam int BIT_CLKS = 64;

  typedef struct {
    logic [7:0] data;
    logic       fe;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    logic       stop;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  exp_t       expq[$];
  vec_t       vecs[5];
  int         tests = 0;
  int         failed = 0;
  int         done_cnt = 0;
  int         done_t[64];
  int         cyc = 0;
  logic       prev_done = 1'b0;
  logic       busy_seen = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic       last_fe = 1'b0;

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  // One tick every fourth clock: one bit is 64 clocks.
  initial begin
    logic [1:0] tc;
    tc = 2'd0;
    sample_tick = 1'b0;
    forever begin
      @(negedge clk_100MHz);
      sample_tick = (tc == 2'd0);
      tc = tc + 2'd1;
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboard: every rx_done must match the oldest expected frame.
  always @(negedge clk_100MHz) begin
    if (reset) begin
      if (rx_busy) busy_seen = 1'b1;
      if (rx_done) begin
        check("done_width", {31'd0, prev_done}, 32'd0);
        check("busy_low_with_done", {31'd0, rx_busy}, 32'd0);
        check("done_expected", {31'd0, expq.size() != 0}, 32'd1);
        if (expq.size() != 0) begin
          exp_t e;
          e = expq.pop_front();
          check("data_out", {24'd0, data_out}, {24'd0, e.data});
          check("framing_error", {31'd0, framing_error}, {31'd0, e.fe});
          last_data = e.data;
          last_fe = e.fe;
        end
        if (done_cnt < 64) done_t[done_cnt] = cyc;
        done_cnt++;
      end
      prev_done = rx_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(BIT_CLKS);
    end
    if (stop) begin
      rx = 1'b1;
      wait_clks(BIT_CLKS);
    end else begin
      // Low across the stop sample point, then idle long enough for the
      // trailing low to be rejected as a false start.
      rx = 1'b0;
      wait_clks(48);
      rx = 1'b1;
      wait_clks(80);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic fe);
    exp_t e;
    e.data = d;
    e.fe = fe;
    expq.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 2000) begin
      @(negedge clk_100MHz);
      n++;
    end
    check(name, expq.size(), 32'd0);
    wait_clks(2);
  endtask

  initial begin
    int d0;
    int diff;
    logic [7:0] rb;
    logic rs;

    vecs[0] = '{din: 8'hA5, stop: 1'b1, gap: 100, exp_data: 8'hA5, exp_fe: 1'b0};
    vecs[1] = '{din: 8'h00, stop: 1'b1, gap: 0,   exp_data: 8'h00, exp_fe: 1'b0};
    vecs[2] = '{din: 8'hFF, stop: 1'b1, gap: 100, exp_data: 8'hFF, exp_fe: 1'b0};
    vecs[3] = '{din: 8'h3C, stop: 1'b0, gap: 100, exp_data: 8'h3C, exp_fe: 1'b1};
    vecs[4] = '{din: 8'h12, stop: 1'b1, gap: 100, exp_data: 8'h12, exp_fe: 1'b0};

    // Reset and long idle.
    reset = 1'b0;
    rx = 1'b1;
    wait_clks(5);
    reset = 1'b1;
    wait_clks(2);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_rx_done", {31'd0, rx_done}, 32'd0);
    check("rst_framing_error", {31'd0, framing_error}, 32'd0);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    wait_clks(2000);
    check("idle_no_done", done_cnt, 32'd0);
    check("idle_no_busy", {31'd0, busy_seen}, 32'd0);
    check("idle_data_out", {24'd0, data_out}, 32'd0);

    // Directed frame table (entry 1 -> 2 is back-to-back with no gap).
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      push_exp(vecs[i].exp_data, vecs[i].exp_fe);
      send_frame(vecs[i].din, vecs[i].stop);
      if (vecs[i].gap > 0) begin
        rx = 1'b1;
        wait_clks(vecs[i].gap);
        wait_idle("vec_done_timeout");
        check("vec_data_hold", {24'd0, data_out}, {24'd0, vecs[i].exp_data});
        check("vec_fe_hold", {31'd0, framing_error}, {31'd0, vecs[i].exp_fe});
        check("vec_busy_idle", {31'd0, rx_busy}, 32'd0);
      end
    end
    check("table_done_count", done_cnt, 32'd5);
    diff = done_t[2] - done_t[1];
    check("b2b_spacing", {31'd0, (diff >= 636 && diff <= 644)}, 32'd1);

    // Glitch: 8 clocks low must be rejected.
    d0 = done_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    wait_clks(8);
    rx = 1'b1;
    wait_clks(100);
    check("glitch_busy_rose", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_fell", {31'd0, rx_busy}, 32'd0);
    check("glitch_no_done", done_cnt, d0);
    check("glitch_data_hold", {24'd0, data_out}, 32'h12);

    // Reset in the middle of data bit 3 of 0xFF, then a clean 0x5A.
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
    wait_clks(3 * BIT_CLKS + 32);
    check("mid_busy_before_reset", {31'd0, rx_busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_data_out", {24'd0, data_out}, 32'd0);
    check("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
    check("mid_rst_done", {31'd0, rx_done}, 32'd0);
    wait_clks(10);
    expq.delete();
    last_data = 8'h00;
    last_fe = 1'b0;
    reset = 1'b1;
    wait_clks(20);
    d0 = done_cnt;
    push_exp(8'h5A, 1'b0);
    send_frame(8'h5A, 1'b1);
    wait_clks(50);
    wait_idle("mid_done_timeout");
    check("mid_one_done", done_cnt - d0, 32'd1);
    check("mid_data_out", {24'd0, data_out}, 32'h5A);

    // Randomized frames against the frame-level model.
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      push_exp(rb, ~rs);
      send_frame(rb, rs);
      rx = 1'b1;
      if (rs) wait_clks($urandom_range(0, 40));
    end
    wait_clks(50);
    wait_idle("rand_done_timeout");
    check("rand_done_count", done_cnt - d0, 32'd16);
    check("rand_last_data", {24'd0, data_out}, {24'd0, last_data});
    check("rand_last_fe", {31'd0, framing_error}, {31'd0, last_fe});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
